// File: rtl/bar_normalizer_if.sv
// Handshaked word stream into and result stream out of the bar normalizer.
// The slave modport is the normalizer; the master modport is its environment.
interface bar_normalizer_if #(
    parameter int W = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] norm_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] norm_out;
    logic [3:0]   shift_cnt;
    logic         zero;

    modport slave (
        input  in_valid, norm_in, out_ready,
        output in_ready, out_valid, norm_out, shift_cnt, zero
    );

    modport master (
        output in_valid, norm_in, out_ready,
        input  in_ready, out_valid, norm_out, shift_cnt, zero
    );
endinterface

// File: rtl/bar_normalizer.sv
// Left-justifies an accepted word one bit per cycle and reports the leading-zero count.
// All outputs come straight from flops, so no input reaches an output combinationally.
module bar_normalizer #(
    parameter int W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    bar_normalizer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] work_q, work_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         zero_q, zero_d;
    logic         in_ready_q, out_valid_q;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    cnt_d = 4'd0;
                    if (bus.norm_in == '0) begin
                        work_d  = '0;
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        work_d  = bus.norm_in;
                        zero_d  = 1'b0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // A nonzero word always reaches MSB=1 within W-1 shifts, so the count cannot wrap.
                if (work_q[W-1]) begin
                    state_d = DONE;
                end else begin
                    work_d = {work_q[W-2:0], 1'b0};
                    cnt_d  = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= 4'd0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.norm_out  = work_q;
    assign bus.shift_cnt = cnt_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_bar_normalizer.sv
// Self-checking bench: directed cases with literal expectations plus randomized traffic
// compared every cycle against a transaction-level model of the normalizer.
module tb_bar_normalizer;
    localparam int W = 8;

    logic clock;
    logic reset_n;
    int   cyc;
    int   n_chk;
    int   n_fail;
    bit   chk_en;

    bar_normalizer_if #(.W(W)) bus ();

    bar_normalizer #(.W(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference: leading zeros and left-justified value from plain arithmetic.
    function automatic int lead_zeros(input logic [W-1:0] w);
        int k = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (w[i]) break;
            k++;
        end
        return k;
    endfunction

    // Transaction model: 0 = can accept, 1 = working (edges left), 2 = result presented.
    int           m_stage;
    int           m_left;
    logic [W-1:0] m_norm;
    int           m_cnt;
    logic         m_zero;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_stage <= 0;
        end else begin
            case (m_stage)
                0: if (bus.in_valid) begin
                    m_cnt  <= (bus.norm_in == '0) ? 0 : lead_zeros(bus.norm_in);
                    m_norm <= bus.norm_in << lead_zeros(bus.norm_in);
                    m_zero <= (bus.norm_in == '0);
                    m_left <= lead_zeros(bus.norm_in);
                    m_stage <= (bus.norm_in == '0) ? 2 : 1;
                end
                1: if (m_left == 0) m_stage <= 2; else m_left <= m_left - 1;
                default: if (bus.out_ready) m_stage <= 0;
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("model in_ready", 32'(bus.in_ready), 32'(m_stage == 0));
            check("model out_valid", 32'(bus.out_valid), 32'(m_stage == 2));
            if (m_stage == 2) begin
                check("model norm_out", 32'(bus.norm_out), 32'(m_norm));
                check("model shift_cnt", 32'(bus.shift_cnt), 32'(m_cnt));
                check("model zero", 32'(bus.zero), 32'(m_zero));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a word once in_ready is seen; returns the cycle number of the accept edge.
    task automatic send(input logic [W-1:0] w, output int a_edge);
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("send timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.norm_in  = w;
        tick();
        a_edge       = cyc;
        bus.in_valid = 1'b0;
        bus.norm_in  = W'($urandom);
    endtask

    // Wait for out_valid, optionally pulsing junk on in_valid while the block is busy.
    task automatic wait_result(input bit junk, output int v_edge);
        int n = 0;
        v_edge = -1;
        while (n < 40) begin
            if (bus.out_valid) begin
                v_edge = cyc;
                break;
            end
            if (junk) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.norm_in  = W'($urandom);
            end
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        if (v_edge < 0) check("result timeout", 32'(bus.out_valid), 32'd1);
    endtask

    // in_valid is held high across the consuming edge; it must not be taken that cycle.
    task automatic consume();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.norm_in   = W'($urandom);
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] w, input logic [W-1:0] e_norm,
                            input int e_cnt, input bit e_zero, input int e_lat);
        int a, v;
        send(w, a);
        wait_result(1'b0, v);
        check({tag, " latency"}, 32'(v - a), 32'(e_lat));
        check({tag, " norm_out"}, 32'(bus.norm_out), 32'(e_norm));
        check({tag, " shift_cnt"}, 32'(bus.shift_cnt), 32'(e_cnt));
        check({tag, " zero"}, 32'(bus.zero), 32'(e_zero));
        consume();
        check({tag, " in_ready after consume"}, 32'(bus.in_ready), 32'd1);
        check({tag, " out_valid after consume"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int a, v;
        n_chk         = 0;
        n_fail        = 0;
        chk_en        = 1'b0;
        cyc           = 0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.norm_in   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset norm_out", 32'(bus.norm_out), 32'd0);
        check("reset shift_cnt", 32'(bus.shift_cnt), 32'd0);
        check("reset zero", 32'(bus.zero), 32'd0);
        chk_en = 1'b1;

        directed("0x13", 8'h13, 8'h98, 3, 1'b0, 4);
        directed("0x80", 8'h80, 8'h80, 0, 1'b0, 1);
        directed("0x01", 8'h01, 8'h80, 7, 1'b0, 8);
        directed("0x00", 8'h00, 8'h00, 0, 1'b1, 0);

        // Result must stay frozen while the consumer stalls.
        send(8'h2C, a);
        wait_result(1'b0, v);
        for (int i = 0; i < 5; i++) begin
            check("stall out_valid", 32'(bus.out_valid), 32'd1);
            check("stall norm_out", 32'(bus.norm_out), 32'hB0);
            check("stall shift_cnt", 32'(bus.shift_cnt), 32'd2);
            check("stall zero", 32'(bus.zero), 32'd0);
            tick();
        end
        consume();
        check("stall release in_ready", 32'(bus.in_ready), 32'd1);

        // A second word offered mid-shift is ignored.
        send(8'h04, a);
        tick();
        bus.in_valid = 1'b1;
        bus.norm_in  = 8'hFF;
        tick();
        bus.in_valid = 1'b0;
        wait_result(1'b0, v);
        check("ignore latency", 32'(v - a), 32'd6);
        check("ignore norm_out", 32'(bus.norm_out), 32'h80);
        check("ignore shift_cnt", 32'(bus.shift_cnt), 32'd5);
        consume();

        // Reset mid-shift discards the word.
        send(8'h01, a);
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midreset in_ready", 32'(bus.in_ready), 32'd1);
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset norm_out", 32'(bus.norm_out), 32'd0);
        check("midreset shift_cnt", 32'(bus.shift_cnt), 32'd0);
        check("midreset zero", 32'(bus.zero), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midreset no result", 32'(bus.out_valid), 32'd0);
        end

        // Randomized traffic; the model compare covers every cycle.
        for (int t = 0; t < 80; t++) begin
            logic [W-1:0] w;
            case ($urandom_range(0, 3))
                0:       w = '0;
                1:       w = W'(1) << $urandom_range(0, W - 1);
                default: w = W'($urandom);
            endcase
            send(w, a);
            wait_result(1'b1, v);
            repeat ($urandom_range(0, 3)) tick();
            consume();
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "simulation did not finish");
    end
endmodule
